// File: rtl/tape_rec_pkg.sv
// Shared types and default timing for the cassette recorder.
// Ticks assume a 24 MHz clk_sys.
package tape_rec_pkg;

    typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} frame_state_t;
    typedef enum logic [1:0] {GLITCH, ONE, ZERO, TIMEOUT} bit_class_t;

    localparam int DEF_MIN_TICKS   = 2400;
    localparam int DEF_SPLIT_TICKS = 7488;
    localparam int DEF_MAX_TICKS   = 14400;

    function automatic bit_class_t classify(input int period, input int min_t,
                                            input int split_t, input int max_t);
        if (period >= max_t) return TIMEOUT;
        else if (period < min_t) return GLITCH;
        else if (period < split_t) return ONE;
        else return ZERO;
    endfunction

endpackage

// File: rtl/tape_period_meter.sv
// Synchronises the cassette line, times rising-edge to rising-edge periods
// and turns each valid period into a decoded bit.
module tape_period_meter
    import tape_rec_pkg::*;
#(
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int SPLIT_TICKS = DEF_SPLIT_TICKS,
    parameter int MAX_TICKS   = DEF_MAX_TICKS
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic enable,
    input  logic disarm,
    input  logic tape_out,
    output logic bit_valid,
    output logic bit_value,
    output logic timeout
);
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic          sync1, sync2, sync_prev, edge_q, armed;
    logic [CW-1:0] cnt;
    bit_class_t    cls;

    always_comb cls = classify(32'(cnt), MIN_TICKS, SPLIT_TICKS, MAX_TICKS);

    // bit_valid and timeout are single-cycle strobes with no backpressure:
    // the framer must consume them in the cycle they are high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            edge_q    <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            bit_valid <= 1'b0;
            bit_value <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sync1     <= tape_out;
            sync2     <= sync1;
            sync_prev <= sync2;
            edge_q    <= sync2 & ~sync_prev;
            bit_valid <= 1'b0;
            timeout   <= 1'b0;
            if (!enable) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else begin
                if (edge_q && !armed) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else if (edge_q && (cls == ONE || cls == ZERO)) begin
                    bit_valid <= 1'b1;
                    bit_value <= (cls == ONE);
                    cnt       <= '0;
                end else if (cnt != MAX_C) begin
                    // Glitch edges fall through here so the period keeps growing.
                    cnt <= cnt + ONE_C;
                    if (cnt == MAX_C - ONE_C) begin
                        timeout <= 1'b1;
                        armed   <= 1'b0;
                    end
                end
                if (disarm) armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tape_recorder.sv
// Oric cassette recorder: frames decoded bits into bytes (start, 8 data
// LSB first, odd parity, stop) and writes them into the TAP buffer.
module tape_recorder
    import tape_rec_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int SPLIT_TICKS = DEF_SPLIT_TICKS,
    parameter int MAX_TICKS   = DEF_MAX_TICKS
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              tape_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   tape_len,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow
);
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    logic         bit_valid, bit_value, timeout;
    logic         commit, abort_stop;
    frame_state_t state, state_nx;
    logic [2:0]   bitcnt, bitcnt_nx;
    logic [7:0]   shreg, shreg_nx;
    logic         par, par_nx;

    tape_period_meter #(
        .MIN_TICKS   (MIN_TICKS),
        .SPLIT_TICKS (SPLIT_TICKS),
        .MAX_TICKS   (MAX_TICKS)
    ) u_meter (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .disarm    (abort_stop),
        .tape_out  (tape_out),
        .bit_valid (bit_valid),
        .bit_value (bit_value),
        .timeout   (timeout)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= HUNT;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
        end else begin
            state  <= state_nx;
            bitcnt <= bitcnt_nx;
            shreg  <= shreg_nx;
            par    <= par_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bitcnt_nx  = bitcnt;
        shreg_nx   = shreg;
        par_nx     = par;
        commit     = 1'b0;
        abort_stop = 1'b0;
        if (!enable || clear || timeout) begin
            state_nx  = HUNT;
            bitcnt_nx = '0;
        end else if (bit_valid) begin
            case (state)
                HUNT: begin
                    // Leader and trailing stop bits are ones; only a zero starts a frame.
                    if (!bit_value) begin
                        state_nx  = DATA;
                        bitcnt_nx = '0;
                    end
                end
                DATA: begin
                    shreg_nx  = {bit_value, shreg[7:1]};
                    bitcnt_nx = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = bit_value;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = HUNT;
                    if (bit_value) commit = 1'b1;
                    else abort_stop = 1'b1;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    assign busy = (state != HUNT);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            tape_len   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                tape_len   <= '0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (commit) begin
                    if (!tape_len[ADDR_W]) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= tape_len[ADDR_W-1:0];
                        wr_data  <= shreg;
                        tape_len <= tape_len + LEN_ONE;
                        if (par != ~^shreg) parity_err <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (abort_stop || (timeout && state != HUNT)) frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tape_recorder.sv
// Bench for tape_recorder: period-level reference model, write scoreboard,
// directed scenarios and randomized byte streams.
module tb_tape_recorder;
  localparam int ADDR_W  = 2;
  localparam int MIN_T   = 24;
  localparam int SPLIT_T = 75;
  localparam int MAX_T   = 144;
  localparam int CAP     = 1 << ADDR_W;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              tape_out = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   tape_len;
  logic              busy, parity_err, frame_err, overflow;

  tape_recorder #(
    .ADDR_W(ADDR_W), .MIN_TICKS(MIN_T), .SPLIT_TICKS(SPLIT_T), .MAX_TICKS(MAX_T)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .clear(clear),
    .tape_out(tape_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tape_len(tape_len), .busy(busy), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [7:0] last_wr_data = 8'h00;
  logic [ADDR_W+7:0] exp_q[$];

  // reference model state: bits of the frame being collected, arming, counters
  bit m_armed;
  int m_len;
  bit m_perr, m_ferr, m_ovf;
  bit m_frame[$];
  int pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void m_reset_all();
    m_armed = 0; m_len = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
    m_frame.delete(); pending = 0;
  endfunction

  function automatic void m_commit(input logic [7:0] d, input bit p);
    if (m_len < CAP) begin
      exp_q.push_back({ADDR_W'(m_len), d});
      m_len++;
      if (p != ~^d) m_perr = 1;
    end else begin
      m_ovf = 1;
    end
  endfunction

  function automatic void m_bit(input bit b);
    logic [7:0] d;
    if (m_frame.size() == 0 && b) return;
    m_frame.push_back(b);
    if (m_frame.size() == 11) begin
      for (int i = 0; i < 8; i++) d[i] = m_frame[1+i];
      if (m_frame[10]) m_commit(d, m_frame[9]);
      else begin m_ferr = 1; m_armed = 0; end
      m_frame.delete();
    end
  endfunction

  function automatic void m_timeout();
    if (m_frame.size() != 0) m_ferr = 1;
    m_frame.delete();
    m_armed = 0;
  endfunction

  // The model sees one rising edge per call; the period just ended is 'pending'.
  function automatic void m_edge();
    if (!m_armed) m_armed = 1;
    else m_bit(pending < SPLIT_T);
  endfunction

  // driver tasks
  task automatic pulse(input int p, input bit glitch);
    m_edge();
    tape_out = 1'b1;
    repeat (8) @(negedge clk_sys);
    if (glitch) begin
      tape_out = 1'b0;
      repeat (3) @(negedge clk_sys);
      tape_out = 1'b1;
      repeat (4) @(negedge clk_sys);
      tape_out = 1'b0;
      repeat (p - 15) @(negedge clk_sys);
    end else begin
      tape_out = 1'b0;
      repeat (p - 8) @(negedge clk_sys);
    end
    pending = p;
    if (pending >= MAX_T && m_armed) m_timeout();
  endtask

  function automatic int short_p();
    return $urandom_range(30, 65);
  endfunction

  function automatic int long_p();
    return $urandom_range(85, 130);
  endfunction

  task automatic leader(input int n);
    for (int i = 0; i < n; i++) pulse(short_p(), 1'b0);
  endtask

  task automatic send_bit(input bit b, input int gl);
    pulse(b ? short_p() : long_p(), (gl != 0) && ($urandom_range(0, 99) < gl));
  endtask

  task automatic send_byte(input logic [7:0] d, input bit flip, input bit stop, input int gl);
    send_bit(1'b0, gl);
    for (int i = 0; i < 8; i++) send_bit(d[i], gl);
    send_bit((~^d) ^ flip, gl);
    send_bit(stop, gl);
  endtask

  task automatic quiet();
    pulse(170, 1'b0);
  endtask

  task automatic clear_pulse();
    @(negedge clk_sys);
    clear = 1'b1;
    @(negedge clk_sys);
    clear = 1'b0;
    m_len = 0; m_perr = 0; m_ferr = 0; m_ovf = 0; m_frame.delete();
    pending += 2;
  endtask

  task automatic check_state(input string name);
    chk({name, " tape_len"}, 32'(tape_len), 32'(m_len));
    chk({name, " parity_err"}, 32'(parity_err), 32'(m_perr));
    chk({name, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({name, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({name, " busy"}, 32'(busy), 32'(m_frame.size() != 0));
    chk({name, " writes outstanding"}, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk_sys) begin
    if (!reset && wr_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected write: addr %0h data %0h", wr_addr, wr_data);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          fails++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   wr_addr, wr_data, e[ADDR_W+7:8], e[7:0]);
        end
      end
      last_wr_data = wr_data;
      wr_count++;
    end
  end

  initial begin
    int base;
    m_reset_all();
    enable = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset tape_len", 32'(tape_len), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // clean 0x16 after a long leader
    leader(20);
    send_byte(8'h16, 1'b0, 1'b1, 0);
    quiet();
    chk("t1 writes", 32'(wr_count), 32'd1);
    chk("t1 data", 32'(last_wr_data), 32'h16);
    chk("t1 addr", 32'(wr_addr), 32'd0);
    chk("t1 len", 32'(tape_len), 32'd1);
    check_state("t1");

    // parity flipped: still written, flag raised
    leader(3);
    send_byte(8'h16, 1'b1, 1'b1, 0);
    quiet();
    chk("t2 data", 32'(last_wr_data), 32'h16);
    chk("t2 len", 32'(tape_len), 32'd2);
    chk("t2 parity_err", 32'(parity_err), 32'd1);
    check_state("t2");
    clear_pulse();

    // bad stop bit then a good frame
    base = wr_count;
    leader(4);
    send_byte(8'hA5, 1'b0, 1'b0, 0);
    leader(4);
    chk("t3 no write", 32'(wr_count - base), 32'd0);
    chk("t3 frame_err", 32'(frame_err), 32'd1);
    send_byte(8'h24, 1'b0, 1'b1, 0);
    quiet();
    chk("t3 data", 32'(last_wr_data), 32'h24);
    chk("t3 addr", 32'(wr_addr), 32'd0);
    check_state("t3");
    clear_pulse();

    // glitches inside every bit period
    leader(3);
    send_byte(8'h16, 1'b0, 1'b1, 100);
    quiet();
    chk("t4 data", 32'(last_wr_data), 32'h16);
    chk("t4 len", 32'(tape_len), 32'd1);
    chk("t4 parity_err", 32'(parity_err), 32'd0);
    check_state("t4");
    clear_pulse();

    // overflow with a 4-byte buffer, then clear
    base = wr_count;
    for (int i = 0; i < 5; i++) begin
      leader(2);
      send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1, 0);
    end
    quiet();
    chk("t5 writes", 32'(wr_count - base), 32'd4);
    chk("t5 len", 32'(tape_len), 32'd4);
    chk("t5 overflow", 32'(overflow), 32'd1);
    chk("t5 last addr", 32'(wr_addr), 32'd3);
    check_state("t5");
    clear_pulse();
    @(negedge clk_sys);
    chk("t5 cleared len", 32'(tape_len), 32'd0);
    chk("t5 cleared flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    // timeout after four data bits
    base = wr_count;
    leader(3);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    m_edge();
    tape_out = 1'b1;
    repeat (8) @(negedge clk_sys);
    tape_out = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("t6 busy mid", 32'(busy), 32'd1);
    repeat (142) @(negedge clk_sys);
    pending = 170;
    m_timeout();
    chk("t6 frame_err", 32'(frame_err), 32'd1);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 no write", 32'(wr_count - base), 32'd0);
    check_state("t6");
    clear_pulse();

    // enable drop mid-byte discards silently
    leader(3);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    chk("t7 busy before", 32'(busy), 32'd1);
    enable = 1'b0;
    m_armed = 0; m_frame.delete();
    repeat (10) @(negedge clk_sys);
    enable = 1'b1;
    pending = 0;
    chk("t7 busy", 32'(busy), 32'd0);
    chk("t7 frame_err", 32'(frame_err), 32'd0);
    leader(3);
    send_byte(8'h3C, 1'b0, 1'b1, 0);
    quiet();
    chk("t7 data", 32'(last_wr_data), 32'h3C);
    check_state("t7");

    // asynchronous reset in the middle of a byte
    leader(3);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    chk("t8 busy before", 32'(busy), 32'd1);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("t8 async len", 32'(tape_len), 32'd0);
    chk("t8 async busy", 32'(busy), 32'd0);
    chk("t8 async wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
    chk("t8 async flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    chk("t8 writes outstanding", 32'(exp_q.size()), 32'd0);
    m_reset_all();
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // randomized groups of bytes
    for (int g = 0; g < 6; g++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        leader($urandom_range(2, 4));
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) != 0, 20);
      end
      quiet();
      check_state("rand");
      clear_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
